spart_rx: RTL and testbench

Serial receive half of the SPART. Consumes the 16x oversampling enable (`receive_baud`) from the SPART baud generator and samples the asynchronous `rxd` line. Deserializes 8N1 frames, LSB first, into a holding register. Flags data-available, framing error and overrun to the bus interface, which clears them with a read strobe.

---
 rtl/spart_rx.sv | 143 ++++++++++++++
 tb/tb_spart_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled 8N1 deserializer with data-available,
// framing-error and overrun flags cleared by a read strobe.
//
// state | meaning
// IDLE  | waiting for a high-to-low start edge (armed once line seen high)
// START | counting to mid start bit, rejecting short low pulses
// DATA  | sampling each data bit at mid-bit, LSB first
// STOP  | sampling stop bit, then loading the holding register
module spart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 receive_baud,
   input  logic                 rxd,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rda,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bcnt_q, bcnt_d;
   logic                   armed_q, armed_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   rx_data_d;
   logic                   rda_d, frame_err_d, overrun_d;
   logic                   sync1, rxd_s;
   logic                   load;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b1;
         rxd_s     <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bcnt_q    <= '0;
         armed_q   <= 1'b0;
         shift_q   <= '0;
         rx_data   <= '0;
         rda       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sync1     <= rxd;
         rxd_s     <= sync1;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bcnt_q    <= bcnt_d;
         armed_q   <= armed_d;
         shift_q   <= shift_d;
         rx_data   <= rx_data_d;
         rda       <= rda_d;
         frame_err <= frame_err_d;
         overrun   <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      armed_d = armed_q;
      shift_d = shift_q;
      load    = 1'b0;
      if (receive_baud) begin
         case (state_q)
            IDLE: begin
               // A line held low must be seen high again before it can retrigger
               if (armed_q && !rxd_s) begin
                  state_d = START;
                  cnt_d   = '0;
                  armed_d = 1'b0;
               end else if (rxd_s) begin
                  armed_d = 1'b1;
               end
            end
            START: begin
               if (cnt_q == HALF_M1) begin
                  if (!rxd_s) begin
                     state_d = DATA;
                     cnt_d   = '0;
                     bcnt_d  = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == FULL_M1) begin
                  shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                  cnt_d   = '0;
                  if (bcnt_q == LAST_BIT) begin
                     state_d = STOP;
                  end else begin
                     bcnt_d = bcnt_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == FULL_M1) begin
                  load    = 1'b1;
                  state_d = IDLE;
                  armed_d = rxd_s;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A load coinciding with a read wins over the clear
   always_comb begin
      rx_data_d   = rx_data;
      rda_d       = rda & ~rd_en;
      frame_err_d = frame_err & ~rd_en;
      overrun_d   = overrun & ~rd_en;
      if (load) begin
         rx_data_d   = shift_q;
         rda_d       = 1'b1;
         frame_err_d = ~rxd_s;
         overrun_d   = overrun | (rda & ~rd_en);
      end
   end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: frames driven bit-by-bit against a 1-in-4 baud
// tick, flags and data checked against hand-computed values.
module tb_spart_rx;

   logic       clk;
   logic       rst;
   logic       receive_baud;
   logic       rxd;
   logic       rd_en;
   logic [7:0] rx_data;
   logic       rda;
   logic       frame_err;
   logic       overrun;

   int n_total = 0;
   int n_pass  = 0;
   logic [1:0] div = 2'd0;

   spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .receive_baud (receive_baud),
      .rxd          (rxd),
      .rd_en        (rd_en),
      .rx_data      (rx_data),
      .rda          (rda),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tick lands on every fourth posedge; updated on negedges only
   initial begin
      receive_baud = 1'b0;
      forever begin
         @(negedge clk);
         div = div + 2'd1;
         receive_baud = (div == 2'd3);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Returns at the negedge right after the n-th tick edge
   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!receive_baud) @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic pulse_rd();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   // Line is left at the stop-bit level; rd_at_stop strobes rd_en on the stop-sample edge
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rd_at_stop);
      rxd = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_ticks(16);
      end
      rxd = stop_bit;
      if (rd_at_stop) begin
         wait_ticks(8);
         repeat (3) @(negedge clk);
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
         wait_ticks(7);
      end else begin
         wait_ticks(16);
      end
   endtask

   initial begin
      rst   = 1'b1;
      rxd   = 1'b1;
      rd_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_rx_data", 32'(rx_data), 32'h00);
      chk("reset_rda", 32'(rda), 32'h0);
      chk("reset_frame_err", 32'(frame_err), 32'h0);
      chk("reset_overrun", 32'(overrun), 32'h0);
      rst = 1'b0;
      wait_ticks(4);

      // 1: clean 0xA5, then read
      send_frame(8'hA5, 1'b1, 1'b0);
      chk("t1_rx_data", 32'(rx_data), 32'hA5);
      chk("t1_rda", 32'(rda), 32'h1);
      chk("t1_frame_err", 32'(frame_err), 32'h0);
      chk("t1_overrun", 32'(overrun), 32'h0);
      pulse_rd();
      chk("t1_rda_cleared", 32'(rda), 32'h0);
      wait_ticks(4);

      // 2: 4-tick low pulse is a false start; next frame still received
      rxd = 1'b0;
      wait_ticks(4);
      rxd = 1'b1;
      wait_ticks(12);
      chk("t2_false_start_rda", 32'(rda), 32'h0);
      send_frame(8'h3C, 1'b1, 1'b0);
      chk("t2_rx_data", 32'(rx_data), 32'h3C);
      chk("t2_rda", 32'(rda), 32'h1);
      chk("t2_frame_err", 32'(frame_err), 32'h0);
      pulse_rd();
      wait_ticks(4);

      // 3: framing error followed by a held-low line
      send_frame(8'h3C, 1'b0, 1'b0);
      chk("t3_rx_data", 32'(rx_data), 32'h3C);
      chk("t3_rda", 32'(rda), 32'h1);
      chk("t3_frame_err", 32'(frame_err), 32'h1);
      wait_ticks(40);
      chk("t3_hold_rda", 32'(rda), 32'h1);
      chk("t3_hold_rx_data", 32'(rx_data), 32'h3C);
      pulse_rd();
      chk("t3_fe_cleared", 32'(frame_err), 32'h0);
      rxd = 1'b1;
      wait_ticks(120);
      chk("t3_no_retrigger_rda", 32'(rda), 32'h0);
      chk("t3_no_retrigger_data", 32'(rx_data), 32'h3C);

      // 4: back-to-back without reading gives overrun
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      chk("t4_rx_data", 32'(rx_data), 32'h22);
      chk("t4_rda", 32'(rda), 32'h1);
      chk("t4_overrun", 32'(overrun), 32'h1);
      chk("t4_frame_err", 32'(frame_err), 32'h0);
      pulse_rd();
      chk("t4_rda_cleared", 32'(rda), 32'h0);
      chk("t4_fe_cleared", 32'(frame_err), 32'h0);
      chk("t4_ov_cleared", 32'(overrun), 32'h0);
      wait_ticks(4);

      // 5: read coincident with the stop-sample load
      send_frame(8'h11, 1'b1, 1'b0);
      chk("t5_first_rda", 32'(rda), 32'h1);
      send_frame(8'h77, 1'b1, 1'b1);
      chk("t5_rx_data", 32'(rx_data), 32'h77);
      chk("t5_rda", 32'(rda), 32'h1);
      chk("t5_overrun", 32'(overrun), 32'h0);
      chk("t5_frame_err", 32'(frame_err), 32'h0);

      // 6: reset during data bit 3 of 0xFF
      rxd = 1'b0;
      wait_ticks(16);
      rxd = 1'b1;
      wait_ticks(48 + 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_rx_data", 32'(rx_data), 32'h00);
      chk("t6_rst_rda", 32'(rda), 32'h0);
      chk("t6_rst_frame_err", 32'(frame_err), 32'h0);
      chk("t6_rst_overrun", 32'(overrun), 32'h0);
      wait_ticks(16);
      chk("t6_no_partial_rda", 32'(rda), 32'h0);
      send_frame(8'h5A, 1'b1, 1'b0);
      chk("t6_rx_data", 32'(rx_data), 32'h5A);
      chk("t6_rda", 32'(rda), 32'h1);
      chk("t6_frame_err", 32'(frame_err), 32'h0);
      chk("t6_overrun", 32'(overrun), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
